// File: rtl/eic_ack_ctrl.sv
// eic_ack_ctrl
// Processor-facing end of the EIC request path. It latches the encoded
// request level and vector from the priority logic and presents them to the
// core as a stable RIPL. When the core acknowledges, it issues a one-cycle
// forced-clear strobe back into the matching channel. After that it holds off
// for one cycle so the channel flag and the encoder can settle.
// A higher level arriving while a level is presented pre-empts the current
// presentation. If no acknowledge arrives within ACK_TIMEOUT presented
// cycles, the presentation is dropped, a timeout is flagged, and the request
// itself is left in place.

module eic_ack_ctrl #(
  parameter int EIC_TOTAL_CHANNELS = 64,   // channels behind requestWR/requestIn (1..255)
  parameter int ACK_TIMEOUT        = 255,  // presented cycles without SI_IAck before drop (>=1)
  parameter int CNT_W              = 8     // timeout counter width, must hold ACK_TIMEOUT
) (
  input  logic                          CLK,
  input  logic                          RESET,
  input  logic [7:0]                    EIC_Interrupt,
  input  logic [5:0]                    EIC_Vector,
  input  logic [7:0]                    SI_IPL,
  input  logic                          SI_IAck,
  output logic [7:0]                    CPU_RIPL,
  output logic [5:0]                    CPU_Vector,
  output logic [EIC_TOTAL_CHANNELS-1:0] requestWR,
  output logic [EIC_TOTAL_CHANNELS-1:0] requestIn,
  output logic                          busy,
  output logic                          timeout
);

  // Controller states. IDLE is the only state in which busy is low.
  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_PRESENT = 2'd1,
    S_CLEAR   = 2'd2,
    S_HOLDOFF = 2'd3
  } state_t;

  // Counter value that is seen on the last allowed presented cycle.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  // Map a 1-based encoded level onto a one-hot channel strobe. Level n
  // selects channel n-1. Levels that point beyond the last channel, and
  // level 0, produce no strobe at all.
  function automatic logic [EIC_TOTAL_CHANNELS-1:0] level_to_strobe(input logic [7:0] lvl);
    logic [EIC_TOTAL_CHANNELS-1:0] s;
    s = '0;
    for (int i = 0; i < EIC_TOTAL_CHANNELS; i++) begin
      if (lvl == 8'(i + 1)) begin
        s[i] = 1'b1;
      end else begin
        s[i] = 1'b0;
      end
    end
    return s;
  endfunction

  state_t                        state_q;
  logic [7:0]                    ripl_q;
  logic [5:0]                    vec_q;
  logic [EIC_TOTAL_CHANNELS-1:0] wr_q;
  logic                          busy_q;
  logic                          timeout_q;
  logic [CNT_W-1:0]              cnt_q;

  logic [EIC_TOTAL_CHANNELS-1:0] strobe_d;
  logic                          req_valid_d;
  logic                          req_above_ipl_d;
  logic                          req_above_ripl_d;

  // Decode the request conditions and the clear strobe for the presented level.
  always_comb begin
    strobe_d         = level_to_strobe(ripl_q);
    req_valid_d      = (EIC_Interrupt != 8'd0);
    req_above_ipl_d  = req_valid_d && (EIC_Interrupt > SI_IPL);
    req_above_ripl_d = (EIC_Interrupt > ripl_q);
  end

  // Presentation FSM with registered outputs. The strobe and the timeout are
  // both single-cycle pulses, so they default to zero on every clock edge.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q   <= S_IDLE;
      ripl_q    <= 8'd0;
      vec_q     <= 6'd0;
      wr_q      <= '0;
      busy_q    <= 1'b0;
      timeout_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      wr_q      <= '0;
      timeout_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (req_above_ipl_d) begin
            ripl_q  <= EIC_Interrupt;
            vec_q   <= EIC_Vector;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= S_PRESENT;
          end else begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        end

        S_PRESENT: begin
          if (SI_IAck) begin
            // The acknowledge wins over a same-cycle higher level. The
            // level the core took is the one that gets cleared.
            wr_q    <= strobe_d;
            busy_q  <= 1'b1;
            state_q <= S_CLEAR;
          end else if (!req_valid_d) begin
            // The request was withdrawn, so stop presenting it.
            ripl_q  <= 8'd0;
            vec_q   <= 6'd0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else if (req_above_ripl_d) begin
            // Pre-emption by a higher level restarts the acknowledge window.
            ripl_q  <= EIC_Interrupt;
            vec_q   <= EIC_Vector;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= S_PRESENT;
          end else if (cnt_q == CNT_LAST) begin
            // Lost acknowledge: drop the presentation but leave the channel
            // flag untouched, so the request re-presents from IDLE.
            timeout_q <= 1'b1;
            ripl_q    <= 8'd0;
            vec_q     <= 6'd0;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            state_q   <= S_IDLE;
          end else begin
            cnt_q   <= cnt_q + CNT_ONE;
            busy_q  <= 1'b1;
            state_q <= S_PRESENT;
          end
        end

        S_CLEAR: begin
          ripl_q  <= 8'd0;
          vec_q   <= 6'd0;
          busy_q  <= 1'b1;
          state_q <= S_HOLDOFF;
        end

        S_HOLDOFF: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end

        default: begin
          ripl_q  <= 8'd0;
          vec_q   <= 6'd0;
          cnt_q   <= '0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign CPU_RIPL   = ripl_q;
  assign CPU_Vector = vec_q;
  assign requestWR  = wr_q;
  assign requestIn  = '0;
  assign busy       = busy_q;
  assign timeout    = timeout_q;

endmodule

// File: tb/tb_eic_ack_ctrl.sv
// Directed bench for eic_ack_ctrl. It runs a table of per-cycle vectors and
// then two hand-written multi-cycle sequences: lost acknowledge, and ack to idle.
module tb_eic_ack_ctrl;

  localparam int N  = 64;
  localparam int TO = 4;

  logic         CLK = 1'b0;
  logic         RESET;
  logic [7:0]   EIC_Interrupt;
  logic [5:0]   EIC_Vector;
  logic [7:0]   SI_IPL;
  logic         SI_IAck;
  logic [7:0]   CPU_RIPL;
  logic [5:0]   CPU_Vector;
  logic [N-1:0] requestWR;
  logic [N-1:0] requestIn;
  logic         busy;
  logic         timeout;

  int checks = 0;
  int errors = 0;

  eic_ack_ctrl #(.EIC_TOTAL_CHANNELS(N), .ACK_TIMEOUT(TO), .CNT_W(8)) dut (
    .CLK(CLK), .RESET(RESET), .EIC_Interrupt(EIC_Interrupt), .EIC_Vector(EIC_Vector),
    .SI_IPL(SI_IPL), .SI_IAck(SI_IAck), .CPU_RIPL(CPU_RIPL), .CPU_Vector(CPU_Vector),
    .requestWR(requestWR), .requestIn(requestIn), .busy(busy), .timeout(timeout)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic       rst;
    logic [7:0] irq;
    logic [5:0] vec;
    logic [7:0] ipl;
    logic       ack;
    logic [7:0] e_ripl;
    logic [5:0] e_vec;
    int         e_wr;    // strobed channel index, -1 for none
    logic       e_busy;
    logic       e_to;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic rst, input logic [7:0] irq, input logic [5:0] vec,
                     input logic [7:0] ipl, input logic ack, input logic [7:0] e_ripl,
                     input logic [5:0] e_vec, input int e_wr, input logic e_busy,
                     input logic e_to);
    vec_t v;
    v.rst = rst; v.irq = irq; v.vec = vec; v.ipl = ipl; v.ack = ack;
    v.e_ripl = e_ripl; v.e_vec = e_vec; v.e_wr = e_wr; v.e_busy = e_busy; v.e_to = e_to;
    tbl.push_back(v);
  endtask

  task automatic chk(input string name, input int idx, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic [7:0] irq, input logic [5:0] vec,
                       input logic [7:0] ipl, input logic ack);
    RESET = rst; EIC_Interrupt = irq; EIC_Vector = vec; SI_IPL = ipl; SI_IAck = ack;
    @(posedge CLK);
    #1;
  endtask

  initial begin
    logic [63:0] ew;
    int          n;
    logic        saw_wr;
    logic        hit;

    RESET = 1'b1; EIC_Interrupt = 8'd0; EIC_Vector = 6'd0; SI_IPL = 8'd0; SI_IAck = 1'b0;

    //  rst  irq     vec     ipl    ack   ripl    evec    wr  busy  to
    add(1'b1, 8'd5,  6'h15, 8'd0, 1'b0, 8'd0,  6'h00, -1, 1'b0, 1'b0); // reset wins
    add(1'b0, 8'd3,  6'h03, 8'd4, 1'b0, 8'd0,  6'h00, -1, 1'b0, 1'b0); // below IPL
    add(1'b0, 8'd4,  6'h04, 8'd4, 1'b0, 8'd0,  6'h00, -1, 1'b0, 1'b0); // equal IPL
    add(1'b0, 8'd5,  6'h15, 8'd0, 1'b0, 8'd5,  6'h15, -1, 1'b1, 1'b0); // present 5
    add(1'b0, 8'd5,  6'h15, 8'd0, 1'b0, 8'd5,  6'h15, -1, 1'b1, 1'b0);
    add(1'b0, 8'd5,  6'h15, 8'd0, 1'b0, 8'd5,  6'h15, -1, 1'b1, 1'b0);
    add(1'b0, 8'd5,  6'h15, 8'd0, 1'b1, 8'd5,  6'h15,  4, 1'b1, 1'b0); // ack -> bit 4
    add(1'b0, 8'd0,  6'h00, 8'd0, 1'b0, 8'd0,  6'h00, -1, 1'b1, 1'b0); // holdoff
    add(1'b0, 8'd0,  6'h00, 8'd0, 1'b0, 8'd0,  6'h00, -1, 1'b0, 1'b0); // idle
    add(1'b0, 8'd2,  6'h02, 8'd0, 1'b0, 8'd2,  6'h02, -1, 1'b1, 1'b0); // present 2
    add(1'b0, 8'd9,  6'h29, 8'd0, 1'b0, 8'd9,  6'h29, -1, 1'b1, 1'b0); // pre-empt 9
    add(1'b0, 8'd9,  6'h29, 8'd0, 1'b1, 8'd9,  6'h29,  8, 1'b1, 1'b0); // bit 8 only
    add(1'b0, 8'd0,  6'h00, 8'd0, 1'b0, 8'd0,  6'h00, -1, 1'b1, 1'b0);
    add(1'b0, 8'd0,  6'h00, 8'd0, 1'b0, 8'd0,  6'h00, -1, 1'b0, 1'b0);
    add(1'b0, 8'd2,  6'h02, 8'd0, 1'b0, 8'd2,  6'h02, -1, 1'b1, 1'b0); // present 2
    add(1'b0, 8'd9,  6'h29, 8'd0, 1'b1, 8'd2,  6'h02,  1, 1'b1, 1'b0); // ack beats 9
    add(1'b0, 8'd9,  6'h29, 8'd0, 1'b0, 8'd0,  6'h00, -1, 1'b1, 1'b0); // holdoff
    add(1'b0, 8'd9,  6'h29, 8'd0, 1'b0, 8'd0,  6'h00, -1, 1'b0, 1'b0); // idle
    add(1'b0, 8'd9,  6'h29, 8'd0, 1'b0, 8'd9,  6'h29, -1, 1'b1, 1'b0); // 9 presented
    add(1'b0, 8'd9,  6'h29, 8'd0, 1'b1, 8'd9,  6'h29,  8, 1'b1, 1'b0);
    add(1'b0, 8'd0,  6'h00, 8'd0, 1'b0, 8'd0,  6'h00, -1, 1'b1, 1'b0);
    add(1'b0, 8'd0,  6'h00, 8'd0, 1'b0, 8'd0,  6'h00, -1, 1'b0, 1'b0);
    add(1'b0, 8'd7,  6'h07, 8'd0, 1'b0, 8'd7,  6'h07, -1, 1'b1, 1'b0); // present 7
    add(1'b0, 8'd3,  6'h03, 8'd0, 1'b0, 8'd7,  6'h07, -1, 1'b1, 1'b0); // lower ignored
    add(1'b0, 8'd0,  6'h00, 8'd0, 1'b0, 8'd0,  6'h00, -1, 1'b0, 1'b0); // withdrawn
    add(1'b0, 8'd0,  6'h00, 8'd0, 1'b1, 8'd0,  6'h00, -1, 1'b0, 1'b0); // ack in idle
    add(1'b0, 8'd70, 6'h2A, 8'd0, 1'b0, 8'd70, 6'h2A, -1, 1'b1, 1'b0); // out of range
    add(1'b0, 8'd70, 6'h2A, 8'd0, 1'b1, 8'd70, 6'h2A, -1, 1'b1, 1'b0); // no strobe
    add(1'b0, 8'd0,  6'h00, 8'd0, 1'b0, 8'd0,  6'h00, -1, 1'b1, 1'b0);
    add(1'b0, 8'd0,  6'h00, 8'd0, 1'b0, 8'd0,  6'h00, -1, 1'b0, 1'b0);
    add(1'b0, 8'd5,  6'h15, 8'd0, 1'b0, 8'd5,  6'h15, -1, 1'b1, 1'b0); // present 5
    add(1'b1, 8'd5,  6'h15, 8'd0, 1'b0, 8'd0,  6'h00, -1, 1'b0, 1'b0); // reset in PRESENT
    add(1'b0, 8'd0,  6'h00, 8'd0, 1'b0, 8'd0,  6'h00, -1, 1'b0, 1'b0);
    add(1'b0, 8'd5,  6'h15, 8'd0, 1'b0, 8'd5,  6'h15, -1, 1'b1, 1'b0);
    add(1'b1, 8'd5,  6'h15, 8'd0, 1'b1, 8'd0,  6'h00, -1, 1'b0, 1'b0); // reset beats ack
    add(1'b0, 8'd0,  6'h00, 8'd0, 1'b0, 8'd0,  6'h00, -1, 1'b0, 1'b0);
    add(1'b0, 8'd5,  6'h15, 8'd0, 1'b0, 8'd5,  6'h15, -1, 1'b1, 1'b0);
    add(1'b0, 8'd5,  6'h15, 8'd0, 1'b1, 8'd5,  6'h15,  4, 1'b1, 1'b0); // CLEAR
    add(1'b1, 8'd0,  6'h00, 8'd0, 1'b0, 8'd0,  6'h00, -1, 1'b0, 1'b0); // reset in CLEAR
    add(1'b0, 8'd0,  6'h00, 8'd0, 1'b0, 8'd0,  6'h00, -1, 1'b0, 1'b0); // straight to idle

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].rst, tbl[i].irq, tbl[i].vec, tbl[i].ipl, tbl[i].ack);
      ew = (tbl[i].e_wr < 0) ? 64'd0 : (64'd1 << tbl[i].e_wr);
      chk("ripl",      i, 64'(CPU_RIPL),  64'(tbl[i].e_ripl));
      if (tbl[i].e_ripl != 8'd0 || tbl[i].rst) begin
        chk("vector",  i, 64'(CPU_Vector), 64'(tbl[i].e_vec));
      end
      chk("requestWR", i, requestWR,       ew);
      chk("requestIn", i, requestIn,       64'd0);
      chk("busy",      i, 64'(busy),      64'(tbl[i].e_busy));
      chk("timeout",   i, 64'(timeout),   64'(tbl[i].e_to));
    end

    // Lost acknowledge: the timeout lands after TO presented cycles, and the
    // still-pending request is re-presented on the next IDLE cycle.
    drive(1'b0, 8'd6, 6'h06, 8'd0, 1'b0);
    chk("to_entry_ripl", 100, 64'(CPU_RIPL), 64'd6);
    n = 0; saw_wr = 1'b0; hit = 1'b0;
    while (!hit && n < 20) begin
      drive(1'b0, 8'd6, 6'h06, 8'd0, 1'b0);
      n++;
      if (requestWR != '0) saw_wr = 1'b1;
      if (timeout) hit = 1'b1;
    end
    chk("to_seen",     101, 64'(hit),      64'd1);
    chk("to_cycles",   102, 64'(n),        64'(TO));
    chk("to_ripl",     103, 64'(CPU_RIPL), 64'd0);
    chk("to_busy",     104, 64'(busy),     64'd0);
    chk("to_no_wr",    105, 64'(saw_wr),   64'd0);
    drive(1'b0, 8'd6, 6'h06, 8'd0, 1'b0);
    chk("to_repres",   106, 64'(CPU_RIPL), 64'd6);
    chk("to_pulse1",   107, 64'(timeout),  64'd0);

    // Ack to idle: the strobe comes the cycle after the ack, and busy drops
    // three edges after the ack.
    drive(1'b0, 8'd6, 6'h06, 8'd0, 1'b1);
    chk("ack_strobe",  108, requestWR,     64'd1 << 5);
    n = 1;
    while (busy && n < 20) begin
      drive(1'b0, 8'd0, 6'h00, 8'd0, 1'b0);
      n++;
    end
    chk("ack_to_idle", 109, 64'(n),        64'd3);
    chk("ack_idle_ripl", 110, 64'(CPU_RIPL), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
